// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the multiply/divide sequencer: operation
// and state encodings plus the default operand width.
package cpu_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative multiply/divide datapath: one shift-add multiply step and one
// restoring-divide step per enabled cycle on unsigned (magnitude) operands.
// MULDIV_EARLY_OUT_EN adds a multiplier-exhausted flag for early MUL exit.
module muldiv_datapath
  import cpu_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic               clk,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem
`ifdef MULDIV_EARLY_OUT_EN
  ,
  output logic               mplier_zero
`endif
);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   dvsr;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               fits;

  // The partial remainder never exceeds the divisor, so a successful
  // subtraction always fits back into WIDTH bits.
  assign shifted = {rem, quot[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, dvsr});
  assign diff    = shifted[WIDTH-1:0] - dvsr;

`ifdef MULDIV_EARLY_OUT_EN
  assign mplier_zero = (mplier == '0);
`endif

  // Operand load on start, then one multiply and one divide step per cycle;
  // the controller picks whichever result matches the running operation.
  always_ff @(posedge clk) begin
    if (load) begin
      prod   <= '0;
      mcand  <= {{WIDTH{1'b0}}, a_in};
      mplier <= b_in;
      rem    <= '0;
      quot   <= a_in;
      dvsr   <= b_in;
    end else if (step) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      rem    <= fits ? diff : shifted[WIDTH-1:0];
      quot   <= {quot[WIDTH-2:0], fits};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared iterative multiply/divide unit. Owns the HI/LO
// pair, the iteration counter and the stall request to the hazard unit.
// MULDIV_EARLY_OUT_EN: MUL finishes as soon as the multiplier is exhausted.
module muldiv_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_e,
  input  logic [1:0]       op_e,
  input  logic [WIDTH-1:0] src_a_e,
  input  logic [WIDTH-1:0] src_b_e,
  input  logic             hilo_use_d,
  input  logic             hi_we_w,
  input  logic             lo_we_w,
  input  logic [WIDTH-1:0] wdata_w,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall_req,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  muldiv_state_t      state, state_next;
  muldiv_op_t         op;
  logic               go, step, fix, mul_last, is_signed, is_div_op;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_abs, b_abs, a_raw;
  logic               sign_q, sign_r, b_zero, is_div_q;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot, rem, q_fix, r_fix;

  assign op        = muldiv_op_t'(op_e);
  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
  assign is_div_op = (op == MD_DIV) || (op == MD_DIVU);
  assign a_abs     = (is_signed && src_a_e[WIDTH-1]) ? -src_a_e : src_a_e;
  assign b_abs     = (is_signed && src_b_e[WIDTH-1]) ? -src_b_e : src_b_e;

`ifdef MULDIV_EARLY_OUT_EN
  logic mplier_zero;
  assign mul_last = (cnt == CW'(1)) || mplier_zero;
`else
  assign mul_last = (cnt == CW'(1));
`endif

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk         (clk),
    .load        (go),
    .step        (step),
    .a_in        (a_abs),
    .b_in        (b_abs),
    .prod        (prod),
    .quot        (quot),
    .rem         (rem)
`ifdef MULDIV_EARLY_OUT_EN
    ,
    .mplier_zero (mplier_zero)
`endif
  );

  assign busy      = (state != ST_IDLE);
  assign stall_req = hilo_use_d & (busy | go);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_next = state;
    go         = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    case (state)
      ST_IDLE: begin
        go = start_e;
        if (start_e) state_next = is_div_op ? ST_DIV : ST_MUL;
      end
      ST_MUL: begin
        step = 1'b1;
        if (mul_last) state_next = ST_FIX;
      end
      ST_DIV: begin
        step = 1'b1;
        if (cnt == CW'(1)) state_next = ST_FIX;
      end
      ST_FIX: begin
        fix        = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Iteration counter: loaded with WIDTH on start, counts down per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (go)   cnt <= CW'(WIDTH);
    else if (step) cnt <= cnt - CW'(1);
    else if (fix)  cnt <= '0;
  end

  // Capture what the final sign fix-up and divide-by-zero result need.
  always_ff @(posedge clk) begin
    if (go) begin
      a_raw    <= src_a_e;
      b_zero   <= (src_b_e == '0);
      is_div_q <= is_div_op;
      sign_q   <= is_signed & (src_a_e[WIDTH-1] ^ src_b_e[WIDTH-1]);
      sign_r   <= is_signed & src_a_e[WIDTH-1];
    end
  end

  // MIN / -1 needs no special case: |MIN| is 2^(WIDTH-1), and negating it
  // in WIDTH bits yields MIN again with a zero remainder.
  assign prod_fix = sign_q ? -prod : prod;
  assign q_fix    = sign_q ? -quot : quot;
  assign r_fix    = sign_r ? -rem  : rem;

  // Architectural HI/LO and the sticky divide-by-zero flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      if (go) div_zero <= 1'b0;
      if (fix) begin
        if (!is_div_q) begin
          {hi, lo} <= prod_fix;
        end else if (b_zero) begin
          lo       <= '1;
          hi       <= a_raw;
          div_zero <= 1'b1;
        end else begin
          lo <= q_fix;
          hi <= r_fix;
        end
      end else if (state == ST_IDLE) begin
        if (hi_we_w) hi <= wdata_w;
        if (lo_we_w) lo <= wdata_w;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: directed corner cases followed by randomized
// operations, all compared against a 64-bit arithmetic reference model.
module tb_muldiv_ctrl;
  import cpu_pkg::*;

  localparam int W = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_e, hilo_use_d, hi_we_w, lo_we_w;
  logic [1:0]    op_e;
  logic [W-1:0]  src_a_e, src_b_e, wdata_w;
  logic [W-1:0]  hi, lo;
  logic          busy, stall_req, div_zero;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_e    (start_e),
    .op_e       (op_e),
    .src_a_e    (src_a_e),
    .src_b_e    (src_b_e),
    .hilo_use_d (hilo_use_d),
    .hi_we_w    (hi_we_w),
    .lo_we_w    (lo_we_w),
    .wdata_w    (wdata_w),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .stall_req  (stall_req),
    .div_zero   (div_zero)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic        m_dz   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Architectural result of one operation, from plain integer arithmetic.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int                sa, sb;
    longint            p;
    longint unsigned   pu;
    sa = a;
    sb = b;
    m_dz = 1'b0;
    case (op)
      MD_MULT: begin
        p = longint'(sa) * longint'(sb);
        {m_hi, m_lo} = p;
      end
      MD_MULTU: begin
        pu = {32'b0, a} * {32'b0, b};
        {m_hi, m_lo} = pu;
      end
      default: begin
        if (b == 0) begin
          m_lo = '1;
          m_hi = a;
          m_dz = 1'b1;
        end else if (op == MD_DIV && a == MIN && b == '1) begin
          m_lo = MIN;
          m_hi = '0;
        end else if (op == MD_DIV) begin
          m_lo = sa / sb;
          m_hi = sa % sb;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
    endcase
  endtask

  // Cycles busy stays high for one operation.
  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] b);
    int          k;
    logic [31:0] bm;
    k = W;
`ifdef MULDIV_EARLY_OUT_EN
    if (op == MD_MULT || op == MD_MULTU) begin
      bm = (op == MD_MULT && b[31]) ? -b : b;
      if (bm == 0) k = 1;
      else begin
        for (int i = 0; i < W; i++) if (bm[i]) k = i + 2;
        if (k > W) k = W;
      end
    end
`else
    bm = b;
    if (op == MD_MULT && bm == 0) k = W;
`endif
    return k + 1;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic use_d, input string tag);
    @(posedge clk); #1;
    start_e    = 1'b1;
    op_e       = op;
    src_a_e    = a;
    src_b_e    = b;
    hilo_use_d = use_d;
    @(negedge clk);
    chk({tag, ".stall_go"}, stall_req, use_d);
    @(posedge clk); #1;
    start_e = 1'b0;
    src_a_e = $urandom;
    src_b_e = $urandom;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input string tag);
    int lat;
    int stall_bad;
    issue(op, a, b, use_d, tag);
    model(op, a, b);
    stall_bad = 0;
    for (lat = 0; lat <= 100; lat++) begin
      @(negedge clk);
      if (!busy) break;
      if (stall_req !== use_d) stall_bad++;
    end
    chk({tag, ".latency"}, lat, exp_latency(op, b));
    chk({tag, ".stall_busy_bad"}, stall_bad, 0);
    chk({tag, ".stall_after"}, stall_req, 1'b0);
    chk({tag, ".hi"}, hi, m_hi);
    chk({tag, ".lo"}, lo, m_lo);
    chk({tag, ".div_zero"}, div_zero, m_dz);
    hilo_use_d = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start_e = 1'b0; op_e = '0; src_a_e = '0; src_b_e = '0;
    hilo_use_d = 1'b0; hi_we_w = 1'b0; lo_we_w = 1'b0; wdata_w = '0;
    #12;
    chk("rst.hi", hi, 0);
    chk("rst.lo", lo, 0);
    chk("rst.busy", busy, 0);
    chk("rst.div_zero", div_zero, 0);
    chk("rst.stall", stall_req, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // mthi / mtlo while idle
    @(posedge clk); #1; hi_we_w = 1'b1; wdata_w = 32'h1234_5678;
    @(posedge clk); #1; hi_we_w = 1'b0; lo_we_w = 1'b1; wdata_w = 32'h9ABC_DEF0;
    @(posedge clk); #1; lo_we_w = 1'b0;
    @(negedge clk);
    chk("mthi", hi, 32'h1234_5678);
    chk("mtlo", lo, 32'h9ABC_DEF0);

    run_op(MD_MULTU, '1, '1, 1'b1, "multu_max");
    run_op(MD_MULT, -32'sd3, 32'sd7, 1'b0, "mult_neg");
    run_op(MD_DIV, -32'sd7, 32'sd2, 1'b1, "div_neg");
    run_op(MD_DIVU, 32'd100, 32'd0, 1'b0, "divu_zero");
    run_op(MD_MULT, -32'sd3, 32'sd7, 1'b0, "mult_clr_dz");
    run_op(MD_DIV, MIN, '1, 1'b1, "div_ovf");
    run_op(MD_DIV, 32'sd7, -32'sd2, 1'b0, "div_negb");
    run_op(MD_DIV, -32'sd9, 32'd0, 1'b0, "div_zero_neg");
    run_op(MD_MULTU, 32'd5, 32'd1, 1'b0, "multu_5x1");
    run_op(MD_MULT, MIN, MIN, 1'b0, "mult_min");

    // asynchronous reset partway through a divide
    issue(MD_DIV, 32'd1000, 32'd3, 1'b1, "div_rst");
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.busy", busy, 0);
    chk("rst_mid.hi", hi, 0);
    chk("rst_mid.lo", lo, 0);
    chk("rst_mid.stall", stall_req, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    hilo_use_d = 1'b0;
    run_op(MD_DIVU, 32'd1000, 32'd3, 1'b1, "after_rst");

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: ra = '0;
        1: ra = MIN;
        2: ra = '1;
        3: ra = $urandom_range(0, 20);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = MIN;
        2: rb = '1;
        3: rb = $urandom_range(0, 20);
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
